// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage - PC register, imem req/ack, decode valid/ready.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic        jump_en,
  input  logic        jalr_en,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic        fetch_fault,
  output logic        misalign_trap
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pco_q, pco_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   target;

  // Redirect priority: JALR over JAL/branch over sequential.
  always_comb begin
    target = pco_q + 32'd4;
    if (jalr_en) begin
      target = (rs1_data + imm) & ~32'h1;
    end else if (jump_en || branch_taken) begin
      target = pco_q + imm;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    valid_d = valid_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pco_d   = pc_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (target[1:0] != 2'b00) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end else begin
            pc_d = target;
          end
`else
          pc_d = target & ~32'h3;
`endif
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      pco_q   <= RESET_PC;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
  assign misalign_trap = trap_q;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign misalign_trap = 1'b0;
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pco_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random memory latency / decode stall bench for fetch_unit
// against a PC-level reference model, plus directed redirect and timeout cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic        jump_en;
  logic        jalr_en;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        fetch_fault;
  logic        misalign_trap;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .jump_en      (jump_en),
    .jalr_en      (jalr_en),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .fetch_fault  (fetch_fault),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          br;
    bit          j;
    bit          jr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] tgt;
  } dir_t;

  dir_t dq[$];

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] exp_pc;
  bit exp_req_now, exp_valid_now, exp_trap_now;
  bit in_req, drop_ack, seq_only, tgt_pend;
  logic [31:0] tgt_exp;
  int wait_left, lat_min, lat_max, hold_len, hold_left;
  int hold_cnt, last_hold, cur_req_len, last_req_len, req_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] memf(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Reference next-PC from the architectural redirect rules.
  function automatic logic [31:0] next_pc(bit br, bit j, bit jr,
                                          logic [31:0] im, logic [31:0] r1,
                                          logic [31:0] pc, output bit trap);
    logic [31:0] t;
    if (jr) t = (r1 + im) & ~32'h1;
    else if (j || br) t = pc + im;
    else t = pc + 32'd4;
    trap = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t % 4 != 0) begin
      trap = 1'b1;
      t = 32'h0000_0100;
    end
`else
    t = t - (t % 4);
`endif
    return t;
  endfunction

  task automatic step();
    bit first, tr;
    @(negedge clk);
    first = exp_valid_now;
    if (exp_req_now) chk("req_after_consume", imem_req, 1);
    if (exp_valid_now) chk("valid_after_ack", instr_valid, 1);
    chk("misalign_trap", misalign_trap, exp_trap_now);
    exp_req_now = 0;
    exp_valid_now = 0;
    exp_trap_now = 0;
    imem_ack = 0;
    imem_rdata = $urandom;
    instr_ready = 0;
    branch_taken = 1'($urandom);
    jump_en = 1'($urandom);
    jalr_en = 1'($urandom);
    imm = $urandom;
    rs1_data = $urandom;
    if (imem_req) begin
      chk("imem_addr", imem_addr, exp_pc);
      chk("no_valid_in_fetch", instr_valid, 0);
      if (tgt_pend) begin
        chk("dir_target", imem_addr, tgt_exp);
        tgt_pend = 0;
      end
      if (!in_req) begin
        in_req = 1;
        cur_req_len = 0;
        wait_left = $urandom_range(lat_max, lat_min);
      end
      cur_req_len++;
      if (drop_ack) req_cnt++;
      else if (wait_left == 0) begin
        imem_ack = 1;
        imem_rdata = memf(imem_addr);
        in_req = 0;
        last_req_len = cur_req_len;
        exp_valid_now = 1;
      end else wait_left--;
    end
    if (instr_valid) begin
      chk("req_low_in_hold", imem_req, 0);
      chk("instr_out", instr_out, memf(exp_pc));
      chk("pc_out", pc_out, exp_pc);
      if (first) begin
        hold_left = (hold_len >= 0) ? hold_len : $urandom_range(3, 0);
        hold_cnt = 0;
      end
      hold_cnt++;
      if (hold_left == 0) begin
        instr_ready = 1;
        last_hold = hold_cnt;
        if (dq.size() != 0) begin
          dir_t e = dq.pop_front();
          branch_taken = e.br;
          jump_en = e.j;
          jalr_en = e.jr;
          imm = e.imm;
          rs1_data = e.rs1;
          tgt_exp = e.tgt;
          tgt_pend = 1;
        end else if (seq_only) begin
          branch_taken = 0;
          jump_en = 0;
          jalr_en = 0;
        end else begin
          int k = $urandom_range(3, 0);
          branch_taken = (k == 1);
          jump_en = (k == 2) || (k == 3 && 1'($urandom));
          jalr_en = (k == 3);
          imm = ($urandom_range(7, 0) == 0) ? $urandom : ($urandom & ~32'h3);
        end
        exp_pc = next_pc(branch_taken, jump_en, jalr_en, imm, rs1_data,
                         exp_pc, tr);
        exp_trap_now = tr;
        exp_req_now = 1;
      end else hold_left--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    imem_ack = 0;
    instr_ready = 0;
    @(negedge clk);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h13);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_trap", misalign_trap, 0);
    rst = 0;
    exp_pc = 32'h0;
    exp_req_now = 0;
    exp_valid_now = 0;
    exp_trap_now = 0;
    in_req = 0;
    tgt_pend = 0;
  endtask

  initial begin
    rst = 1;
    imem_ack = 0;
    imem_rdata = 0;
    instr_ready = 0;
    branch_taken = 0;
    jump_en = 0;
    jalr_en = 0;
    imm = 0;
    rs1_data = 0;
    drop_ack = 0;
    seq_only = 1;
    lat_min = 0;
    lat_max = 0;
    hold_len = 0;
    hold_left = 0;
    last_hold = 0;
    last_req_len = 0;
    req_cnt = 0;
    wait_left = 0;
    do_reset();

    for (int i = 0; i < 8; i++) step();

    lat_min = 3;
    lat_max = 3;
    hold_len = 5;
    for (int i = 0; i < 24; i++) step();
    chk("req_cycles_lat3", last_req_len, 4);
    chk("hold_cycles_5", last_hold, 6);

    seq_only = 0;
    lat_min = 0;
    lat_max = 2;
    hold_len = 0;
    dq.push_back('{0, 0, 1, 32'h0, 32'h100, 32'h100});
    dq.push_back('{1, 0, 0, 32'hFFFF_FFF0, 32'h0, 32'hF0});
    dq.push_back('{0, 1, 1, 32'h4, 32'h2001, 32'h2004});
    dq.push_back('{0, 0, 1, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC});
    dq.push_back('{0, 0, 0, 32'h0, 32'h0, 32'h0});
    dq.push_back('{0, 0, 1, 32'h0, 32'h0, 32'h0});
`ifdef FETCH_MISALIGN_TRAP_EN
    dq.push_back('{0, 1, 0, 32'h6, 32'h0, 32'h100});
`else
    dq.push_back('{0, 1, 0, 32'h6, 32'h0, 32'h4});
`endif
    for (int i = 0; i < 300 && (dq.size() != 0 || tgt_pend); i++) step();
    chk("dir_drained", 32'(dq.size()) + 32'(tgt_pend), 0);

    lat_max = 3;
    hold_len = -1;
    for (int i = 0; i < 3000; i++) step();

    do_reset();
    drop_ack = 1;
    req_cnt = 0;
    for (int i = 0; i < 40 && !fetch_fault; i++) step();
    chk("fault_set", fetch_fault, 1);
    chk("timeout_len", req_cnt, 16);
    chk("req_drop", imem_req, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_fault", fetch_fault, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_valid", instr_valid, 0);
    end

    drop_ack = 0;
    do_reset();
    step();
    chk("addr_after_fault_rst", imem_addr, 32'h0);
    chk("req_after_fault_rst", imem_req, 1);
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage feeding the decode/immediate-generation path of the RV32I core.
- Holds the PC register and issues word requests to instruction memory over a req/ack handshake.
- Presents one instruction with its PC to decode under a valid/ready handshake.
- Computes the next PC from the redirect controls and immediate returned by the downstream stages: sequential, branch, JAL or JALR.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ACK_TIMEOUT, 16, max cycles imem_req may stay unacknowledged before fetch_fault.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned-target trap (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the request (= pc, bits[1:0]=00).
- imem_ack  in  1  memory accepts the request; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_out  out  32  instruction presented to decode.
- pc_out  out  32  PC of instr_out.
- instr_valid  out  1  instr_out/pc_out valid.
- instr_ready  in  1  decode consumes instr_out this cycle.
- branch_taken  in  1  conditional branch resolved taken (sampled only on consume).
- jump_en  in  1  JAL (sampled only on consume).
- jalr_en  in  1  JALR (sampled only on consume).
- imm  in  32  sign-extended immediate from the immediate generator.
- rs1_data  in  32  rs1 operand for JALR.
- fetch_fault  out  1  sticky; memory ack timeout.
- misalign_trap  out  1  one-cycle pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Reset values (visible the cycle after rst is sampled high):
  - pc = RESET_PC, pc_out = RESET_PC
  - instr_out = 32'h0000_0013 (NOP), instr_valid = 0
  - imem_req = 0, fetch_fault = 0, misalign_trap = 0
  - timeout counter = 0, state = IDLE
- rst high in any state aborts any outstanding request (imem_req = 0 next cycle).
- IDLE: after rst deasserts, -> FETCH on the next edge.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - imem_ack = 1: instr_out <= imem_rdata, pc_out <= pc, instr_valid <= 1, counter cleared, -> HOLD.
  - Otherwise counter increments. When it reaches ACK_TIMEOUT: fetch_fault <= 1 (sticky until rst), imem_req drops, -> HALT.
- HOLD:
  - instr_valid = 1, imem_req = 0; imem_ack is ignored.
  - instr_out and pc_out stay stable until consumed.
  - On instr_valid && instr_ready: pc <= next_pc, instr_valid <= 0, -> FETCH.
  - Minimum throughput: one instruction per 2 cycles (zero-wait memory).
- HALT: all outputs held, instr_valid = 0; exits only on rst.
- next_pc, evaluated only on a consume cycle, priority high to low:
  - jalr_en: (rs1_data + imm) & ~32'h1
  - jump_en or branch_taken: pc_out + imm
  - else: pc_out + 4
- next_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0; pc_out + negative imm wraps.
- Redirect inputs are ignored in all cycles that are not consume cycles.
- Simultaneous jalr_en and jump_en: JALR wins.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - next_pc[1:0] != 00 on a consume cycle: pc <= TRAP_VEC, misalign_trap = 1 for exactly that cycle, then -> FETCH normally.
  - pc_out of the trapping instruction is not altered.
- Undefined:
  - next_pc[1:0] is forced to 00 before loading pc.
  - misalign_trap is tied 0.

Test Plan:
1. Reset then zero-wait memory (ack same cycle as req), instr_ready = 1 always -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every other cycle; first instr_out = mem[0].
2. Memory acks after 3 cycles; instr_ready held 0 for 5 cycles in HOLD -> imem_req high for 4 cycles; instr_out/pc_out unchanged while instr_ready = 0; no second request issued.
3. Consume at pc_out = 0x100 with branch_taken = 1, imm = 0xFFFF_FFF0 -> next imem_addr = 0xF0. Then jalr_en = 1 and jump_en = 1, rs1_data = 0x2001, imm = 4 -> imem_addr = 0x2004.
4. pc_out = 0xFFFF_FFFC, no redirect -> next imem_addr = 0x0.
5. No imem_ack for ACK_TIMEOUT = 16 cycles -> fetch_fault = 1 on cycle 16, imem_req = 0, state HALT. rst -> fetch_fault = 0, imem_addr = RESET_PC.
6. FETCH_MISALIGN_TRAP_EN defined, jump_en with imm = 0x6 at pc_out = 0x0 -> misalign_trap one-cycle pulse, next imem_addr = 0x100. Undefined, same stimulus -> imem_addr = 0x4, misalign_trap = 0.
